// File: rtl/fft_pkg.sv
// Shared constants, reader state type and bit-reversal helper for the
// 512-point FFT output reorder buffer.
//   N      : points per frame
//   LANES  : samples per beat
//   ROWS   : beats per frame
//   DW     : sample width (two's complement, passed through untouched)
package fft_pkg;

   localparam int unsigned N     = 512;
   localparam int unsigned LANES = 16;
   localparam int unsigned ROWS  = N / LANES;
   localparam int unsigned LOG2N = $clog2(N);
   localparam int unsigned LOG2L = $clog2(LANES);
   localparam int unsigned LOG2R = $clog2(ROWS);
   localparam int unsigned DW    = 13;

   typedef enum logic {
      IDLE,
      READ
   } rd_state_e;

   // Reverses the low w bits of v; bits above w return as zero.
   function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned w);
      logic [31:0] src;
      logic [31:0] res;
      src = v;
      res = '0;
      for (int unsigned i = 0; i < w; i++) begin
         res = {res[30:0], src[0]};
         src = {1'b0, src[31:1]};
      end
      return res;
   endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One frame buffer of the ping-pong pair.
//   clk, rstn  : clock, asynchronous active-low reset (FULL flag only)
//   we         : write one beat this cycle
//   wr_row     : beat index of the incoming bit-reversed beat
//   wr_data    : LANES samples, each {I, Q}
//   rd_row     : natural-order row to present on rd_data
//   rd_data    : LANES contiguous samples of row rd_row, each {I, Q}
//   set_full   : frame completed into this bank
//   clr_full   : frame fully read out of this bank
//   full       : bank holds a complete, unread frame
module fft_reorder_bank
   import fft_pkg::*;
(
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          we,
   input  logic [LOG2R-1:0]              wr_row,
   input  logic [LANES-1:0][2*DW-1:0]    wr_data,
   input  logic [LOG2R-1:0]              rd_row,
   output logic [LANES-1:0][2*DW-1:0]    rd_data,
   input  logic                          set_full,
   input  logic                          clr_full,
   output logic                          full
);

   logic [2*DW-1:0]  mem_q [N];
   logic [LOG2N-1:0] wr_addr [LANES];
   logic             full_q;
   logic             full_d;

   // Element n = {wr_row, m} lands at bitrev(n) = {rev(m), rev(wr_row)}.
   always_comb begin
      for (int unsigned m = 0; m < LANES; m++) begin
         wr_addr[m] = {LOG2L'(bitrev(m, LOG2L)), LOG2R'(bitrev(32'(wr_row), LOG2R))};
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         for (int unsigned m = 0; m < LANES; m++) begin
            mem_q[wr_addr[m]] <= wr_data[m];
         end
      end
   end

   always_comb begin
      for (int unsigned j = 0; j < LANES; j++) begin
         rd_data[j] = mem_q[{rd_row, LOG2L'(j)}];
      end
   end

   always_comb begin
      full_d = full_q;
      if (clr_full) full_d = 1'b0;
      if (set_full) full_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) full_q <= 1'b0;
      else       full_q <= full_d;
   end

   assign full = full_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT output frames into natural frequency order
// using two frame banks so consecutive frames stream without stalls.
//   clk, rstn        : clock, asynchronous active-low reset
//   valid_in         : beat on din_i/din_q is valid
//   din_i, din_q     : LANES x DW samples, bit-reversed order
//   valid_out        : beat on dout_i/dout_q is valid
//   sof_out          : first row of an output frame
//   dout_i, dout_q   : LANES x DW samples, lane j of row r = bin LANES*r+j
module fft_bitrev_reorder
   import fft_pkg::*;
(
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  valid_in,
   input  logic [LANES*DW-1:0]   din_i,
   input  logic [LANES*DW-1:0]   din_q,
   output logic                  valid_out,
   output logic                  sof_out,
   output logic [LANES*DW-1:0]   dout_i,
   output logic [LANES*DW-1:0]   dout_q
);

   localparam logic [LOG2R-1:0] LAST_ROW = LOG2R'(ROWS - 1);

   logic                        wr_bank_q, wr_bank_d;
   logic [LOG2R-1:0]            wr_row_q, wr_row_d;
   rd_state_e                   state_q, state_d;
   logic                        rd_bank_q, rd_bank_d;
   logic [LOG2R-1:0]            rd_row_q, rd_row_d;
   logic                        valid_q, valid_d;
   logic                        sof_q, sof_d;
   logic [LANES*DW-1:0]         dout_i_q, dout_i_d;
   logic [LANES*DW-1:0]         dout_q_q, dout_q_d;

   logic                        accept;
   logic [1:0]                  bank_we, bank_set, bank_clr, bank_full;
   logic [LANES-1:0][2*DW-1:0]  wr_data;
   logic [LANES-1:0][2*DW-1:0]  rd_data [2];

   always_comb begin
      for (int unsigned m = 0; m < LANES; m++) begin
         wr_data[m] = {din_i[m*DW +: DW], din_q[m*DW +: DW]};
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      fft_reorder_bank u_bank (
         .clk      (clk),
         .rstn     (rstn),
         .we       (bank_we[b]),
         .wr_row   (wr_row_q),
         .wr_data  (wr_data),
         .rd_row   (rd_row_q),
         .rd_data  (rd_data[b]),
         .set_full (bank_set[b]),
         .clr_full (bank_clr[b]),
         .full     (bank_full[b])
      );
   end

   // Writer: a beat aimed at a bank still holding an unread frame is dropped.
   always_comb begin
      wr_bank_d = wr_bank_q;
      wr_row_d  = wr_row_q;
      bank_we   = '0;
      bank_set  = '0;
      accept    = valid_in && !bank_full[wr_bank_q];
      if (accept) begin
         bank_we[wr_bank_q] = 1'b1;
         wr_row_d           = wr_row_q + 1'b1;
         if (wr_row_q == LAST_ROW) begin
            bank_set[wr_bank_q] = 1'b1;
            wr_bank_d           = ~wr_bank_q;
         end
      end
   end

   // Reader: banks are drained in the same alternating order they are filled,
   // so rd_bank simply toggles. rd_row is always 0 while IDLE, so the bank read
   // port can be addressed by rd_row_q in both states.
   always_comb begin
      state_d   = state_q;
      rd_bank_d = rd_bank_q;
      rd_row_d  = rd_row_q;
      valid_d   = 1'b0;
      sof_d     = 1'b0;
      dout_i_d  = dout_i_q;
      dout_q_d  = dout_q_q;
      bank_clr  = '0;
      case (state_q)
         IDLE: begin
            if (bank_full[rd_bank_q]) begin
               valid_d  = 1'b1;
               sof_d    = 1'b1;
               rd_row_d = LOG2R'(1);
               state_d  = READ;
            end
         end
         READ: begin
            valid_d = 1'b1;
            sof_d   = (rd_row_q == '0);
            if (rd_row_q == LAST_ROW) begin
               bank_clr[rd_bank_q] = 1'b1;
               rd_bank_d           = ~rd_bank_q;
               rd_row_d            = '0;
               state_d             = bank_full[~rd_bank_q] ? READ : IDLE;
            end else begin
               rd_row_d = rd_row_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (valid_d) begin
         for (int unsigned j = 0; j < LANES; j++) begin
            dout_i_d[j*DW +: DW] = rd_data[rd_bank_q][j][2*DW-1:DW];
            dout_q_d[j*DW +: DW] = rd_data[rd_bank_q][j][DW-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_bank_q <= 1'b0;
         wr_row_q  <= '0;
         state_q   <= IDLE;
         rd_bank_q <= 1'b0;
         rd_row_q  <= '0;
         valid_q   <= 1'b0;
         sof_q     <= 1'b0;
         dout_i_q  <= '0;
         dout_q_q  <= '0;
      end else begin
         wr_bank_q <= wr_bank_d;
         wr_row_q  <= wr_row_d;
         state_q   <= state_d;
         rd_bank_q <= rd_bank_d;
         rd_row_q  <= rd_row_d;
         valid_q   <= valid_d;
         sof_q     <= sof_d;
         dout_i_q  <= dout_i_d;
         dout_q_q  <= dout_q_d;
      end
   end

   assign valid_out = valid_q;
   assign sof_out   = sof_q;
   assign dout_i    = dout_i_q;
   assign dout_q    = dout_q_q;

   // Upstream must never write into a bank that has not yet been read out.
   a_no_overrun: assert property (@(posedge clk) disable iff (!rstn)
      !(valid_in && bank_full[wr_bank_q]));

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
module tb_fft_bitrev_reorder;
   import fft_pkg::*;

   logic                 clk = 1'b0;
   logic                 rstn;
   logic                 valid_in;
   logic [LANES*DW-1:0]  din_i, din_q;
   logic                 valid_out, sof_out;
   logic [LANES*DW-1:0]  dout_i, dout_q;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned cyc      = 0;

   logic [DW-1:0] fi [3][N];
   logic [DW-1:0] fq [3][N];

   logic [LANES*DW-1:0] q_i [$];
   logic [LANES*DW-1:0] q_q [$];
   logic                q_sof [$];
   int unsigned         q_cyc [$];

   fft_bitrev_reorder dut (
      .clk       (clk),
      .rstn      (rstn),
      .valid_in  (valid_in),
      .din_i     (din_i),
      .din_q     (din_q),
      .valid_out (valid_out),
      .sof_out   (sof_out),
      .dout_i    (dout_i),
      .dout_q    (dout_q)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rstn && valid_out) begin
         q_i.push_back(dout_i);
         q_q.push_back(dout_q);
         q_sof.push_back(sof_out);
         q_cyc.push_back(cyc);
      end
   end

   // Reference: output bin k holds input element n where k = bitrev9(n),
   // i.e. n = bitrev9(k) since the permutation is its own inverse.
   function automatic int unsigned rev9(input int unsigned k);
      int unsigned r = 0;
      for (int b = 0; b < 9; b++)
         if (((k >> b) & 1) == 1) r += (1 << (8 - b));
      return r;
   endfunction

   function automatic logic [LANES*DW-1:0] exp_row(input int f, input int r, input bit want_q);
      logic [LANES*DW-1:0] v;
      for (int j = 0; j < LANES; j++)
         v[j*DW +: DW] = want_q ? fq[f][rev9(LANES*r + j)] : fi[f][rev9(LANES*r + j)];
      return v;
   endfunction

   task automatic clear_mon;
      q_i.delete(); q_q.delete(); q_sof.delete(); q_cyc.delete();
   endtask

   task automatic send_frame(input int f, input int unsigned duty,
                             output int unsigned first_e, output int unsigned last_e);
      first_e = 0;
      last_e  = 0;
      for (int r = 0; r < ROWS; r++) begin
         @(negedge clk);
         while (duty < 100 && $urandom_range(0, 99) >= duty) begin
            valid_in = 1'b0;
            @(negedge clk);
         end
         valid_in = 1'b1;
         for (int m = 0; m < LANES; m++) begin
            din_i[m*DW +: DW] = fi[f][LANES*r + m];
            din_q[m*DW +: DW] = fq[f][LANES*r + m];
         end
         if (r == 0)        first_e = cyc + 1;
         if (r == ROWS - 1) last_e  = cyc + 1;
      end
   endtask

   task automatic stop_input;
      @(negedge clk);
      valid_in = 1'b0;
      din_i    = {LANES{13'h0AA5}};
      din_q    = {LANES{13'h1555}};
   endtask

   task automatic wait_beats(input int unsigned need);
      for (int t = 0; t < 400 && q_i.size() < need; t++) @(negedge clk);
      repeat (40) @(negedge clk);
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      valid_in = 1'b0;
      din_i = '0;
      din_q = '0;
      repeat (3) @(negedge clk);
      n_checks++; if (valid_out !== 1'b0) $display("FAIL reset_valid got %b exp 0", valid_out); else n_pass++;
      n_checks++; if (sof_out !== 1'b0) $display("FAIL reset_sof got %b exp 0", sof_out); else n_pass++;
      n_checks++; if (dout_i !== '0) $display("FAIL reset_dout_i got %h exp 0", dout_i); else n_pass++;
      n_checks++; if (dout_q !== '0) $display("FAIL reset_dout_q got %h exp 0", dout_q); else n_pass++;
      rstn = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_impulse;
      int unsigned fe, le;
      for (int n = 0; n < N; n++) begin fi[0][n] = '0; fq[0][n] = '0; end
      fi[0][1] = DW'(100);
      clear_mon();
      send_frame(0, 100, fe, le);
      stop_input();
      wait_beats(ROWS);
      n_checks++; if (q_i.size() != ROWS) $display("FAIL impulse_count got %0d exp %0d", q_i.size(), ROWS); else n_pass++;
      if (q_i.size() == ROWS) begin
         n_checks++; if (q_cyc[0] != le + 1) $display("FAIL impulse_start got %0d exp %0d", q_cyc[0], le + 1); else n_pass++;
         n_checks++; if (q_i[16][DW-1:0] !== DW'(100)) $display("FAIL impulse_bin256 got %0d exp 100", q_i[16][DW-1:0]); else n_pass++;
         for (int b = 0; b < ROWS; b++) begin
            n_checks++;
            if ({q_i[b], q_q[b]} !== {exp_row(0, b, 1'b0), exp_row(0, b, 1'b1)})
               $display("FAIL impulse_data row %0d got %h/%h exp %h/%h", b, q_i[b], q_q[b], exp_row(0, b, 1'b0), exp_row(0, b, 1'b1));
            else n_pass++;
            n_checks++; if (q_sof[b] !== (b == 0)) $display("FAIL impulse_sof row %0d got %b exp %b", b, q_sof[b], b == 0); else n_pass++;
         end
      end
   endtask

   task automatic load_ramp(input int f);
      for (int n = 0; n < N; n++) begin
         fi[f][n] = DW'(n);
         fq[f][n] = DW'(-n);
      end
   endtask

   task automatic test_ramp_duty(input string tag, input int unsigned duty);
      int unsigned fe, le;
      load_ramp(0);
      clear_mon();
      send_frame(0, duty, fe, le);
      stop_input();
      wait_beats(ROWS);
      n_checks++; if (q_i.size() != ROWS) $display("FAIL %s_count got %0d exp %0d", tag, q_i.size(), ROWS); else n_pass++;
      if (q_i.size() == ROWS) begin
         n_checks++; if (q_i[0][DW +: DW] !== DW'(256)) $display("FAIL %s_row0_lane1 got %0d exp 256", tag, q_i[0][DW +: DW]); else n_pass++;
         for (int b = 0; b < ROWS; b++) begin
            n_checks++;
            if ({q_i[b], q_q[b]} !== {exp_row(0, b, 1'b0), exp_row(0, b, 1'b1)})
               $display("FAIL %s_data row %0d got %h/%h exp %h/%h", tag, b, q_i[b], q_q[b], exp_row(0, b, 1'b0), exp_row(0, b, 1'b1));
            else n_pass++;
            n_checks++; if (q_cyc[b] != le + 1 + b) $display("FAIL %s_timing row %0d got %0d exp %0d", tag, b, q_cyc[b], le + 1 + b); else n_pass++;
            n_checks++; if (q_sof[b] !== (b == 0)) $display("FAIL %s_sof row %0d got %b exp %b", tag, b, q_sof[b], b == 0); else n_pass++;
         end
      end
   endtask

   task automatic test_back_to_back;
      int unsigned fe[3], le[3];
      for (int f = 0; f < 3; f++)
         for (int n = 0; n < N; n++) begin
            fi[f][n] = DW'($urandom);
            fq[f][n] = DW'($urandom);
         end
      clear_mon();
      for (int f = 0; f < 3; f++) send_frame(f, 100, fe[f], le[f]);
      stop_input();
      wait_beats(3 * ROWS);
      n_checks++; if (q_i.size() != 3 * ROWS) $display("FAIL b2b_count got %0d exp %0d", q_i.size(), 3 * ROWS); else n_pass++;
      if (q_i.size() == 3 * ROWS) begin
         for (int b = 0; b < 3 * ROWS; b++) begin
            automatic int f = b / ROWS;
            automatic int r = b % ROWS;
            n_checks++;
            if ({q_i[b], q_q[b]} !== {exp_row(f, r, 1'b0), exp_row(f, r, 1'b1)})
               $display("FAIL b2b_data beat %0d got %h/%h exp %h/%h", b, q_i[b], q_q[b], exp_row(f, r, 1'b0), exp_row(f, r, 1'b1));
            else n_pass++;
            n_checks++; if (q_cyc[b] != fe[0] + ROWS + b) $display("FAIL b2b_timing beat %0d got %0d exp %0d", b, q_cyc[b], fe[0] + ROWS + b); else n_pass++;
            n_checks++; if (q_sof[b] !== (r == 0)) $display("FAIL b2b_sof beat %0d got %b exp %b", b, q_sof[b], r == 0); else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid;
      int unsigned fe, le;
      for (int n = 0; n < N; n++) begin
         fi[1][n] = DW'($urandom);
         fq[1][n] = DW'($urandom);
         fi[0][n] = DW'($urandom);
         fq[0][n] = DW'($urandom);
      end
      clear_mon();
      for (int r = 0; r < 10; r++) begin
         @(negedge clk);
         valid_in = 1'b1;
         for (int m = 0; m < LANES; m++) begin
            din_i[m*DW +: DW] = fi[1][LANES*r + m];
            din_q[m*DW +: DW] = fq[1][LANES*r + m];
         end
      end
      @(negedge clk);
      valid_in = 1'b0;
      rstn = 1'b0;
      repeat (3) begin
         @(negedge clk);
         n_checks++; if (valid_out !== 1'b0) $display("FAIL rstmid_valid_in_reset got %b exp 0", valid_out); else n_pass++;
      end
      rstn = 1'b1;
      send_frame(0, 100, fe, le);
      stop_input();
      wait_beats(ROWS);
      n_checks++; if (q_i.size() != ROWS) $display("FAIL rstmid_count got %0d exp %0d", q_i.size(), ROWS); else n_pass++;
      if (q_i.size() == ROWS) begin
         n_checks++; if (q_cyc[0] != le + 1) $display("FAIL rstmid_start got %0d exp %0d", q_cyc[0], le + 1); else n_pass++;
         for (int b = 0; b < ROWS; b++) begin
            n_checks++;
            if ({q_i[b], q_q[b]} !== {exp_row(0, b, 1'b0), exp_row(0, b, 1'b1)})
               $display("FAIL rstmid_data row %0d got %h/%h exp %h/%h", b, q_i[b], q_q[b], exp_row(0, b, 1'b0), exp_row(0, b, 1'b1));
            else n_pass++;
         end
      end
   endtask

   task automatic test_extremes;
      int unsigned fe, le;
      for (int n = 0; n < N; n++) begin
         fi[0][n] = (n % 2 == 0) ? 13'h1000 : 13'h0FFF;
         fq[0][n] = (n % 2 == 0) ? 13'h0FFF : 13'h1000;
      end
      clear_mon();
      send_frame(0, 100, fe, le);
      stop_input();
      wait_beats(ROWS);
      n_checks++; if (q_i.size() != ROWS) $display("FAIL extreme_count got %0d exp %0d", q_i.size(), ROWS); else n_pass++;
      if (q_i.size() == ROWS) begin
         n_checks++; if (q_i[0][DW-1:0] !== 13'h1000) $display("FAIL extreme_bin0 got %h exp 1000", q_i[0][DW-1:0]); else n_pass++;
         n_checks++; if (q_i[16][DW-1:0] !== 13'h0FFF) $display("FAIL extreme_bin256 got %h exp 0fff", q_i[16][DW-1:0]); else n_pass++;
         for (int b = 0; b < ROWS; b++) begin
            n_checks++;
            if ({q_i[b], q_q[b]} !== {exp_row(0, b, 1'b0), exp_row(0, b, 1'b1)})
               $display("FAIL extreme_data row %0d got %h/%h exp %h/%h", b, q_i[b], q_q[b], exp_row(0, b, 1'b0), exp_row(0, b, 1'b1));
            else n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_ramp_duty("ramp", 100);
      test_back_to_back();
      test_ramp_duty("gapped", 50);
      test_reset_mid();
      test_extremes();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
